elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
Parametrised floor-scheduling core for the Spartan Elevator. It replaces the fixed 4-floor queue/driver pair with an N-floor SCAN scheduler. It accepts floor requests from the keypad path, holds them in a pending bitmap and moves the car one floor per TRAVEL_TICKS strobes. It opens the door for DOOR_TICKS strobes at each serviced floor and keeps its travel direction until no requests remain ahead. It sits between the keypad scanner and the seven-segment and driver logic, and takes its time base from the existing 1 s strobe counter.

Parameters:
NUM_FLOORS, 8, number of floors (2..2^FLOOR_W).
FLOOR_W, 4, floor index width.
TRAVEL_TICKS, 3, tick strobes per one-floor move (1..255).
DOOR_TICKS, 2, tick strobes the door stays open (1..255).
INIT_FLOOR, 0, car floor after reset.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
tick  in  1  one-cycle time-base strobe; timers advance only when tick=1.
req_valid  in  1  request strobe, one request per asserted cycle.
req_floor  in  FLOOR_W  requested floor.
req_err  out  1  one-cycle pulse when req_floor >= NUM_FLOORS.
cur_floor  out  FLOOR_W  current car floor.
dest_floor  out  FLOOR_W  nearest pending floor in the current direction; equals cur_floor when none.
dir_up  out  1  1 = up, 0 = down; holds its last value when idle.
moving  out  1  state == MOVE.
door_open  out  1  state == DOOR.
arrived  out  1  one-cycle pulse on entry to DOOR.
pending  out  NUM_FLOORS  outstanding request bitmap.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation): state=IDLE, cur_floor=INIT_FLOOR, pending=0, dir_up=1, timer=0. All pulses 0, moving=0, door_open=0, dest_floor=INIT_FLOOR.
- Request capture, registered, one-cycle latency:
  - Out-of-range request: pending is unchanged; req_err=1 next cycle.
  - req_floor==cur_floor while in IDLE or DOOR: pending bit is not set. The state goes to or stays in DOOR with timer=0 (door reopens or extends), and arrived pulses only on entry from IDLE.
  - Otherwise pending[req_floor] is set. This includes req_floor==cur_floor while in MOVE.
- States: IDLE, MOVE, DOOR.
- IDLE, when pending!=0, computes direction as follows:
  - If dir_up and any bit above cur_floor, go up.
  - Else if any bit below, go down.
  - Else go up.
  - Then next state is MOVE with timer=0.
- MOVE:
  - On each tick, timer increments.
  - On a tick with timer==TRAVEL_TICKS-1, cur_floor steps ±1 and timer=0.
  - In that same cycle, if pending[next floor]=1, state goes to DOOR and that bit is cleared.
  - The car never leaves the range 0..NUM_FLOORS-1, because a direction is chosen only toward a set bit.
- DOOR:
  - On each tick, timer increments.
  - On a tick with timer==DOOR_TICKS-1, state goes to IDLE and timer=0.
  - Direction is re-evaluated in IDLE on the following cycle.
- Simultaneous events:
  - A request for the floor being cleared in the same cycle is absorbed, so the bit stays 0.
  - A request arriving on the step cycle for a floor other than the next floor is set normally.
  - rst overrides a coincident req_valid.
- dest_floor is combinational from pending, cur_floor and dir_up: the nearest set bit strictly ahead of cur_floor in the current direction.
- No request is ever dropped except out-of-range requests. Duplicate requests are idempotent.

Test Plan:
1. Setup: NUM_FLOORS=8, TRAVEL_TICKS=3, DOOR_TICKS=2, tick held 1, reset at floor 0. Request floor 2 at cycle 0 -> pending=0x04 at cycle 1; moving=1 at cycle 2; cur_floor=1 at cycle 5; cur_floor=2 with door_open=1 and arrived pulse at cycle 8; IDLE with pending=0 at cycle 10.
2. SCAN order: car at floor 3 moving up; requests for 1 and 6 arrive together -> floor 6 is serviced first (dest_floor=6), then the car reverses to 1. pending=0x42 → 0x02 → 0x00.
3. Out-of-range: req_floor=9 with NUM_FLOORS=8 -> req_err pulses for one cycle; pending unchanged; state unchanged.
4. Door hold: while in DOOR at floor 2, request floor 2 -> timer restarts, door_open stays 1 for 2 further ticks, no arrived pulse, pending bit 2 stays 0.
5. Reset mid-move: assert rst while moving between floors 4 and 5 -> next cycle cur_floor=0, pending=0, moving=0, dir_up=1.
6. tick gating: tick held 0 with a pending request -> state goes to MOVE but cur_floor never changes. Pulse tick 3 times -> cur_floor advances by exactly 1.

Source files
------------

// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
//   N-floor SCAN scheduler for the elevator car. Requests are captured into a
//   pending bitmap. The car moves one floor every TRAVEL_TICKS time-base
//   strobes and keeps its direction while requests remain ahead. It opens the
//   door for DOOR_TICKS strobes at every floor it services.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   tick_i         one-cycle time-base strobe; timers advance only on it
//   req_valid_i    request strobe, one request per asserted cycle
//   req_floor_i    requested floor
//   req_err_o      one-cycle pulse after an out-of-range request
//   cur_floor_o    current car floor
//   dest_floor_o   nearest pending floor ahead; equals cur_floor_o when none
//   dir_up_o       travel direction (1 = up), held while idle
//   moving_o       car is travelling between floors
//   door_open_o    door is open
//   arrived_o      one-cycle pulse on entry to the door-open state
//   pending_o      outstanding request bitmap
// -----------------------------------------------------------------------------
module elevator_scheduler #(
   parameter int NUM_FLOORS   = 8,
   parameter int FLOOR_W      = 4,
   parameter int TRAVEL_TICKS = 3,
   parameter int DOOR_TICKS   = 2,
   parameter int INIT_FLOOR   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tick_i,
   input  logic                  req_valid_i,
   input  logic [FLOOR_W-1:0]    req_floor_i,
   output logic                  req_err_o,
   output logic [FLOOR_W-1:0]    cur_floor_o,
   output logic [FLOOR_W-1:0]    dest_floor_o,
   output logic                  dir_up_o,
   output logic                  moving_o,
   output logic                  door_open_o,
   output logic                  arrived_o,
   output logic [NUM_FLOORS-1:0] pending_o
);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

   state_e                state_q, state_d;
   logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  dir_up_q, dir_up_d;
   logic [7:0]            timer_q, timer_d;
   logic                  req_err_q, req_err_d;
   logic                  arrived_q, arrived_d;

   logic                  req_in_range;
   logic                  req_at_car;
   logic                  reopen;
   logic [FLOOR_W-1:0]    next_floor;
   logic [NUM_FLOORS-1:0] req_mask, above_mask, below_mask, next_mask;
   logic [FLOOR_W-1:0]    dest_floor;

   // One extra bit so NUM_FLOORS == 2**FLOOR_W is representable.
   assign req_in_range = ({1'b0, req_floor_i} < (FLOOR_W+1)'(NUM_FLOORS));
   assign req_at_car   = (req_floor_i == cur_floor_q);
   // A request for the car's own floor while stopped reopens the door instead
   // of queueing; while moving it is queued like any other floor.
   assign reopen       = req_valid_i && req_in_range && req_at_car && (state_q != S_MOVE);
   assign next_floor   = dir_up_q ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);

   // One-hot and region masks keep every bitmap access free of variable
   // indexing with a mismatched index width.
   always_comb begin
      req_mask   = '0;
      above_mask = '0;
      below_mask = '0;
      next_mask  = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         req_mask[i]   = (int'(req_floor_i) == i);
         above_mask[i] = (i > int'(cur_floor_q));
         below_mask[i] = (i < int'(cur_floor_q));
         next_mask[i]  = (int'(next_floor) == i);
      end
   end

   // Nearest pending floor strictly ahead: lowest set bit above when going up,
   // highest set bit below when going down.
   always_comb begin
      dest_floor = cur_floor_q;
      if (dir_up_q) begin
         for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pending_q[i] && above_mask[i]) dest_floor = FLOOR_W'(i);
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++)
            if (pending_q[i] && below_mask[i]) dest_floor = FLOOR_W'(i);
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      pending_d   = pending_q;
      dir_up_d    = dir_up_q;
      timer_d     = timer_q;
      arrived_d   = 1'b0;
      req_err_d   = req_valid_i && !req_in_range;

      // Capture first so that a clear of the same bit further down wins and
      // a request for the floor being serviced is absorbed.
      if (req_valid_i && req_in_range && !reopen)
         pending_d = pending_q | req_mask;

      case (state_q)
         S_IDLE: begin
            if (pending_q != '0) begin
               if (dir_up_q && |(pending_q & above_mask))
                  dir_up_d = 1'b1;
               else if (|(pending_q & below_mask))
                  dir_up_d = 1'b0;
               else
                  dir_up_d = 1'b1;
               state_d = S_MOVE;
               timer_d = '0;
            end
         end
         S_MOVE: begin
            if (tick_i) begin
               if (timer_q == 8'(TRAVEL_TICKS - 1)) begin
                  cur_floor_d = next_floor;
                  timer_d     = '0;
                  if (|(pending_q & next_mask)) begin
                     state_d   = S_DOOR;
                     pending_d = pending_d & ~next_mask;
                     arrived_d = 1'b1;
                  end
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
         end
         S_DOOR: begin
            if (tick_i) begin
               if (timer_q == 8'(DOOR_TICKS - 1)) begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (reopen) begin
         state_d   = S_DOOR;
         timer_d   = '0;
         dir_up_d  = dir_up_q;
         arrived_d = (state_q == S_IDLE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cur_floor_q <= FLOOR_W'(INIT_FLOOR);
         pending_q   <= '0;
         dir_up_q    <= 1'b1;
         timer_q     <= '0;
         req_err_q   <= 1'b0;
         arrived_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         pending_q   <= pending_d;
         dir_up_q    <= dir_up_d;
         timer_q     <= timer_d;
         req_err_q   <= req_err_d;
         arrived_q   <= arrived_d;
      end
   end

   assign req_err_o    = req_err_q;
   assign cur_floor_o  = cur_floor_q;
   assign dest_floor_o = dest_floor;
   assign dir_up_o     = dir_up_q;
   assign moving_o     = (state_q == S_MOVE);
   assign door_open_o  = (state_q == S_DOOR);
   assign arrived_o    = arrived_q;
   assign pending_o    = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_scheduler
//   Directed bench for elevator_scheduler (8 floors, 3 travel ticks, 2 door
//   ticks). Expected arrival floors are queued when a request is issued and
//   popped by a monitor each time the DUT pulses arrived_o.
// -----------------------------------------------------------------------------
module tb_elevator_scheduler;

   localparam int NUM_FLOORS = 8;
   localparam int FLOOR_W    = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  tick;
   logic                  req_valid;
   logic [FLOOR_W-1:0]    req_floor;
   logic                  req_err;
   logic [FLOOR_W-1:0]    cur_floor;
   logic [FLOOR_W-1:0]    dest_floor;
   logic                  dir_up;
   logic                  moving;
   logic                  door_open;
   logic                  arrived;
   logic [NUM_FLOORS-1:0] pending;

   int checks = 0;
   int errors = 0;

   logic [FLOOR_W-1:0] arr_q[$];

   elevator_scheduler #(
      .NUM_FLOORS  (NUM_FLOORS),
      .FLOOR_W     (FLOOR_W),
      .TRAVEL_TICKS(3),
      .DOOR_TICKS  (2),
      .INIT_FLOOR  (0)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .tick_i      (tick),
      .req_valid_i (req_valid),
      .req_floor_i (req_floor),
      .req_err_o   (req_err),
      .cur_floor_o (cur_floor),
      .dest_floor_o(dest_floor),
      .dir_up_o    (dir_up),
      .moving_o    (moving),
      .door_open_o (door_open),
      .arrived_o   (arrived),
      .pending_o   (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [FLOOR_W-1:0] f);
      req_valid = 1'b1;
      req_floor = f;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_arrival(input int budget, input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (arrived !== 1'b1 && n < budget);
      check(tag, 32'(arrived), 32'd1);
   endtask

   task automatic wait_floor(input logic [FLOOR_W-1:0] f, input int budget, input string tag);
      int n = 0;
      while (cur_floor !== f && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(cur_floor), 32'(f));
   endtask

   // Arrival scoreboard: every arrived pulse must match the next queued floor.
   always @(posedge clk) begin
      #2;
      if (arrived === 1'b1) begin
         if (arr_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_arrival: observed floor %0d expected none", cur_floor);
         end else begin
            check("arrival_floor", 32'(cur_floor), 32'(arr_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      tick      = 1'b1;
      req_valid = 1'b0;
      req_floor = '0;
      repeat (2) step();
      check("rst_cur_floor", 32'(cur_floor), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_door", 32'(door_open), 32'd0);
      check("rst_dir_up", 32'(dir_up), 32'd1);
      check("rst_dest", 32'(dest_floor), 32'd0);
      check("rst_pulses", 32'({req_err, arrived}), 32'd0);
      rst = 1'b0;

      // Basic trip 0 -> 2: request at cycle 0.
      arr_q.push_back(4'd2);
      request(4'd2);                                         // cycle 1
      check("t1_pending_c1", 32'(pending), 32'h04);
      check("t1_idle_c1", 32'(moving), 32'd0);
      step();                                                // cycle 2
      check("t1_moving_c2", 32'(moving), 32'd1);
      check("t1_dest_c2", 32'(dest_floor), 32'd2);
      repeat (3) step();                                     // cycle 5
      check("t1_floor1_c5", 32'(cur_floor), 32'd1);
      check("t1_moving_c5", 32'(moving), 32'd1);
      repeat (3) step();                                     // cycle 8
      check("t1_floor2_c8", 32'(cur_floor), 32'd2);
      check("t1_door_c8", 32'(door_open), 32'd1);
      check("t1_arrived_c8", 32'(arrived), 32'd1);
      check("t1_pending_c8", 32'(pending), 32'h00);
      step();                                                // cycle 9
      check("t1_arrived_c9", 32'(arrived), 32'd0);
      check("t1_door_c9", 32'(door_open), 32'd1);
      step();                                                // cycle 10
      check("t1_idle_c10", 32'({moving, door_open}), 32'd0);
      check("t1_pending_c10", 32'(pending), 32'h00);

      // Out-of-range request.
      request(4'd9);
      check("t3_req_err", 32'(req_err), 32'd1);
      check("t3_pending", 32'(pending), 32'h00);
      check("t3_state", 32'({moving, door_open}), 32'd0);
      step();
      check("t3_req_err_clear", 32'(req_err), 32'd0);

      // Door hold at floor 2: open from idle, then extend on the last tick.
      arr_q.push_back(4'd2);
      request(4'd2);
      check("t4_door_open", 32'(door_open), 32'd1);
      check("t4_arrived_entry", 32'(arrived), 32'd1);
      step();
      check("t4_door_t1", 32'(door_open), 32'd1);
      request(4'd2);
      check("t4_door_extend", 32'(door_open), 32'd1);
      check("t4_no_arrived", 32'(arrived), 32'd0);
      check("t4_pending", 32'(pending), 32'h00);
      step();
      check("t4_door_still", 32'(door_open), 32'd1);
      step();
      check("t4_door_closed", 32'({moving, door_open}), 32'd0);

      // SCAN order: 6 then 1 queued, car heading up from 2.
      arr_q.push_back(4'd6);
      arr_q.push_back(4'd1);
      request(4'd6);
      check("t2_pending_6", 32'(pending), 32'h40);
      step();
      check("t2_moving", 32'(moving), 32'd1);
      request(4'd1);
      check("t2_pending_42", 32'(pending), 32'h42);
      check("t2_dest_6", 32'(dest_floor), 32'd6);
      check("t2_dir_up", 32'(dir_up), 32'd1);
      wait_arrival(40, "t2_arrive_6");
      check("t2_pending_02", 32'(pending), 32'h02);
      wait_arrival(60, "t2_arrive_1");
      check("t2_pending_00", 32'(pending), 32'h00);
      check("t2_dir_down", 32'(dir_up), 32'd0);
      repeat (2) step();
      check("t2_idle", 32'({moving, door_open}), 32'd0);

      // Reset mid-move between floors 4 and 5, with a coincident request.
      request(4'd7);
      wait_floor(4'd4, 40, "t5_reach_4");
      step();
      check("t5_moving_mid", 32'(moving), 32'd1);
      rst       = 1'b1;
      req_valid = 1'b1;
      req_floor = 4'd5;
      step();
      rst       = 1'b0;
      req_valid = 1'b0;
      check("t5_cur_floor", 32'(cur_floor), 32'd0);
      check("t5_pending", 32'(pending), 32'h00);
      check("t5_moving", 32'(moving), 32'd0);
      check("t5_dir_up", 32'(dir_up), 32'd1);
      step();
      check("t5_pending_after", 32'(pending), 32'h00);

      // Tick gating: no movement without strobes, one floor per 3 strobes.
      tick = 1'b0;
      request(4'd2);
      check("t6_pending", 32'(pending), 32'h04);
      step();
      check("t6_moving", 32'(moving), 32'd1);
      repeat (10) step();
      check("t6_floor_frozen", 32'(cur_floor), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
      check("t6_floor_1", 32'(cur_floor), 32'd1);
      check("t6_still_moving", 32'(moving), 32'd1);
      repeat (5) step();
      check("t6_floor_1_hold", 32'(cur_floor), 32'd1);
      arr_q.push_back(4'd2);
      tick = 1'b1;
      wait_arrival(20, "t6_arrive_2");
      step();

      check("arrivals_drained", 32'(arr_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
